// File: rtl/cpu_params_pkg.sv
// Shared RisKy1 core parameters, load-size and writeback FSM encodings,
// and the memory-to-writeback transfer bundle.
package cpu_params_pkg;

  localparam int unsigned MAX_GPR = 32;
  localparam int unsigned RSZ     = 32;
  localparam int unsigned GPR_ASZ = $clog2(MAX_GPR);

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10
  } ld_size_t;

  typedef enum logic {
    IDLE,
    WAIT_LD
  } wb_state_t;

  typedef struct packed {
    logic               rd_wr;
    logic [GPR_ASZ-1:0] rd_addr;
    logic [RSZ-1:0]     rd_data;
    logic               is_ld;
    ld_size_t           ld_size;
    logic               ld_unsigned;
    logic [1:0]         ld_off;
  } mem_wb_t;

  // x0 is hardwired and addresses beyond the implemented file are dropped
  function automatic logic rd_writes(input logic wr, input logic [GPR_ASZ-1:0] addr);
    return wr && (addr != '0) && ({1'b0, addr} < (GPR_ASZ + 1)'(MAX_GPR));
  endfunction

endpackage

// File: rtl/rbus_intf.sv
// RBUS: single register-file write port from writeback to the GPR block.
interface RBUS_intf;
  import cpu_params_pkg::*;

  logic               Rd_wr;
  logic [GPR_ASZ-1:0] Rd_addr;
  logic [RSZ-1:0]     Rd_data;

  modport master (output Rd_wr, output Rd_addr, output Rd_data);
  modport slave  (input  Rd_wr, input  Rd_addr, input  Rd_data);
endinterface

// File: rtl/wb_stage_ld_align.sv
// Load data alignment: shifts the addressed byte lane down, then
// sign- or zero-extends to register width according to the access size.
module ld_align
  import cpu_params_pkg::*;
(
  input  logic [RSZ-1:0] data,
  input  ld_size_t       size,
  input  logic           ld_unsigned,
  input  logic [1:0]     off,
  output logic [RSZ-1:0] aligned
);

  logic [RSZ-1:0] shifted;

  always_comb begin
    shifted = data >> {off, 3'b000};
    case (size)
      LD_B:    aligned = {{(RSZ-8){~ld_unsigned & shifted[7]}}, shifted[7:0]};
      LD_H:    aligned = {{(RSZ-16){~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RisKy1 writeback stage: retires ALU results and load responses onto RBUS
// and counts retired instructions. Define WB_FWD_EN to expose fwd_* bypass ports.
module wb_stage
  import cpu_params_pkg::*;
(
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               mem_valid,
  output logic               mem_rdy,
  input  logic               mem_rd_wr,
  input  logic [GPR_ASZ-1:0] mem_rd_addr,
  input  logic [RSZ-1:0]     mem_rd_data,
  input  logic               mem_is_ld,
  input  logic [1:0]         mem_ld_size,
  input  logic               mem_ld_unsigned,
  input  logic [1:0]         mem_ld_off,
  input  logic               ld_rsp_valid,
  input  logic [RSZ-1:0]     ld_rsp_data,
  input  logic               ld_rsp_err,
  RBUS_intf.master           gpr_bus,
  output logic               ld_fault,
  output logic [63:0]        instret
`ifdef WB_FWD_EN
  ,
  output logic               fwd_valid,
  output logic [GPR_ASZ-1:0] fwd_addr,
  output logic [RSZ-1:0]     fwd_data
`endif
);

  wb_state_t          state;
  mem_wb_t            mem;
  logic               cap_wr;
  logic [GPR_ASZ-1:0] cap_addr;
  ld_size_t           cap_size;
  logic               cap_unsigned;
  logic [1:0]         cap_off;
  logic [RSZ-1:0]     ld_aligned;

  always_comb begin
    mem             = '0;
    mem.rd_wr       = mem_rd_wr;
    mem.rd_addr     = mem_rd_addr;
    mem.rd_data     = mem_rd_data;
    mem.is_ld       = mem_is_ld;
    mem.ld_size     = ld_size_t'(mem_ld_size);
    mem.ld_unsigned = mem_ld_unsigned;
    mem.ld_off      = mem_ld_off;
  end

  assign mem_rdy = (state == IDLE);

  ld_align u_ld_align (
    .data        (ld_rsp_data),
    .size        (cap_size),
    .ld_unsigned (cap_unsigned),
    .off         (cap_off),
    .aligned     (ld_aligned)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state           <= IDLE;
      gpr_bus.Rd_wr   <= 1'b0;
      gpr_bus.Rd_addr <= '0;
      gpr_bus.Rd_data <= '0;
      ld_fault        <= 1'b0;
      instret         <= '0;
      cap_wr          <= 1'b0;
      cap_addr        <= '0;
      cap_size        <= LD_B;
      cap_unsigned    <= 1'b0;
      cap_off         <= '0;
    end else begin
      gpr_bus.Rd_wr <= 1'b0;
      ld_fault      <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            if (!mem.is_ld) begin
              gpr_bus.Rd_wr   <= rd_writes(mem.rd_wr, mem.rd_addr);
              gpr_bus.Rd_addr <= mem.rd_addr;
              gpr_bus.Rd_data <= mem.rd_data;
              instret         <= instret + 64'd1;
            end else begin
              cap_wr       <= mem.rd_wr;
              cap_addr     <= mem.rd_addr;
              cap_size     <= mem.ld_size;
              cap_unsigned <= mem.ld_unsigned;
              cap_off      <= mem.ld_off;
              state        <= WAIT_LD;
            end
          end
        end
        WAIT_LD: begin
          if (ld_rsp_valid) begin
            state           <= IDLE;
            gpr_bus.Rd_addr <= cap_addr;
            if (ld_rsp_err) begin
              ld_fault <= 1'b1;
            end else begin
              gpr_bus.Rd_wr   <= rd_writes(cap_wr, cap_addr);
              gpr_bus.Rd_data <= ld_aligned;
              instret         <= instret + 64'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = gpr_bus.Rd_wr;
  assign fwd_addr  = gpr_bus.Rd_addr;
  assign fwd_data  = gpr_bus.Rd_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed, table-driven bench for wb_stage (optional WB_FWD_EN ports).
module tb_wb_stage;
  import cpu_params_pkg::*;

  logic               clk_in = 1'b0;
  logic               reset_in;
  logic               mem_valid;
  logic               mem_rdy;
  logic               mem_rd_wr;
  logic [GPR_ASZ-1:0] mem_rd_addr;
  logic [RSZ-1:0]     mem_rd_data;
  logic               mem_is_ld;
  logic [1:0]         mem_ld_size;
  logic               mem_ld_unsigned;
  logic [1:0]         mem_ld_off;
  logic               ld_rsp_valid;
  logic [RSZ-1:0]     ld_rsp_data;
  logic               ld_rsp_err;
  logic               ld_fault;
  logic [63:0]        instret;
`ifdef WB_FWD_EN
  logic               fwd_valid;
  logic [GPR_ASZ-1:0] fwd_addr;
  logic [RSZ-1:0]     fwd_data;
`endif

  RBUS_intf gpr_bus_if ();

  wb_stage dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .mem_valid       (mem_valid),
    .mem_rdy         (mem_rdy),
    .mem_rd_wr       (mem_rd_wr),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .mem_is_ld       (mem_is_ld),
    .mem_ld_size     (mem_ld_size),
    .mem_ld_unsigned (mem_ld_unsigned),
    .mem_ld_off      (mem_ld_off),
    .ld_rsp_valid    (ld_rsp_valid),
    .ld_rsp_data     (ld_rsp_data),
    .ld_rsp_err      (ld_rsp_err),
    .gpr_bus         (gpr_bus_if),
    .ld_fault        (ld_fault),
    .instret         (instret)
`ifdef WB_FWD_EN
    ,
    .fwd_valid       (fwd_valid),
    .fwd_addr        (fwd_addr),
    .fwd_data        (fwd_data)
`endif
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [63:0] exp_instret = '0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        wr;
    logic        exp_wr;
  } alu_vec_t;

  typedef struct {
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [4:0]  addr;
    logic [31:0] rsp;
    logic [31:0] exp_data;
    logic        exp_wr;
  } ld_vec_t;

  alu_vec_t alu_tab [4];
  ld_vec_t  ld_tab  [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid       = 1'b0;
    mem_rd_wr       = 1'b0;
    mem_rd_addr     = '0;
    mem_rd_data     = '0;
    mem_is_ld       = 1'b0;
    mem_ld_size     = 2'b00;
    mem_ld_unsigned = 1'b0;
    mem_ld_off      = 2'b00;
    ld_rsp_valid    = 1'b0;
    ld_rsp_data     = '0;
    ld_rsp_err      = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] addr, input logic [31:0] data, input logic wr);
    mem_valid   = 1'b1;
    mem_is_ld   = 1'b0;
    mem_rd_addr = addr;
    mem_rd_data = data;
    mem_rd_wr   = wr;
  endtask

  task automatic drive_ld(input logic [4:0] addr, input logic [1:0] size,
                          input logic uns, input logic [1:0] off);
    mem_valid       = 1'b1;
    mem_is_ld       = 1'b1;
    mem_rd_wr       = 1'b1;
    mem_rd_addr     = addr;
    mem_rd_data     = 32'h5555_5555;
    mem_ld_size     = size;
    mem_ld_unsigned = uns;
    mem_ld_off      = off;
  endtask

  initial begin
    alu_tab[0] = '{5'd5,  32'hDEAD_BEEF, 1'b1, 1'b1};
    alu_tab[1] = '{5'd0,  32'h0000_1234, 1'b1, 1'b0};
    alu_tab[2] = '{5'd7,  32'h0BAD_F00D, 1'b0, 1'b0};
    alu_tab[3] = '{5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1};

    ld_tab[0] = '{2'b00, 1'b0, 2'd2, 5'd3,  32'h0080_0000, 32'hFFFF_FF80, 1'b1};
    ld_tab[1] = '{2'b00, 1'b1, 2'd2, 5'd3,  32'h0080_0000, 32'h0000_0080, 1'b1};
    ld_tab[2] = '{2'b01, 1'b0, 2'd2, 5'd4,  32'h8001_1234, 32'hFFFF_8001, 1'b1};
    ld_tab[3] = '{2'b01, 1'b1, 2'd0, 5'd4,  32'h8001_8234, 32'h0000_8234, 1'b1};
    ld_tab[4] = '{2'b01, 1'b0, 2'd0, 5'd9,  32'h8001_8234, 32'hFFFF_8234, 1'b1};
    ld_tab[5] = '{2'b10, 1'b0, 2'd0, 5'd10, 32'h1234_5678, 32'h1234_5678, 1'b1};
    ld_tab[6] = '{2'b00, 1'b0, 2'd3, 5'd11, 32'h7F00_0000, 32'h0000_007F, 1'b1};
    ld_tab[7] = '{2'b00, 1'b0, 2'd1, 5'd12, 32'h0000_AB00, 32'hFFFF_FFAB, 1'b1};
    ld_tab[8] = '{2'b11, 1'b0, 2'd0, 5'd13, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1};
    ld_tab[9] = '{2'b00, 1'b0, 2'd0, 5'd0,  32'h0000_00FF, 32'h0000_0000, 1'b0};

    idle_inputs();
    reset_in = 1'b1;
    tick();
    tick();
    chk("reset_rd_wr",    {63'd0, gpr_bus_if.Rd_wr}, 64'd0);
    chk("reset_rd_addr",  {59'd0, gpr_bus_if.Rd_addr}, 64'd0);
    chk("reset_rd_data",  {32'd0, gpr_bus_if.Rd_data}, 64'd0);
    chk("reset_ld_fault", {63'd0, ld_fault}, 64'd0);
    chk("reset_instret",  instret, 64'd0);
    chk("reset_mem_rdy",  {63'd0, mem_rdy}, 64'd1);
`ifdef WB_FWD_EN
    chk("reset_fwd_valid", {63'd0, fwd_valid}, 64'd0);
`endif
    reset_in = 1'b0;
    tick();

    // Non-load table: one instruction, then an idle cycle
    for (int i = 0; i < 4; i++) begin
      drive_alu(alu_tab[i].addr, alu_tab[i].data, alu_tab[i].wr);
      tick();
      idle_inputs();
      exp_instret = exp_instret + 64'd1;
      chk($sformatf("alu%0d_rd_wr", i), {63'd0, gpr_bus_if.Rd_wr}, {63'd0, alu_tab[i].exp_wr});
      chk($sformatf("alu%0d_instret", i), instret, exp_instret);
      if (alu_tab[i].exp_wr) begin
        chk($sformatf("alu%0d_rd_addr", i), {59'd0, gpr_bus_if.Rd_addr}, {59'd0, alu_tab[i].addr});
        chk($sformatf("alu%0d_rd_data", i), {32'd0, gpr_bus_if.Rd_data}, {32'd0, alu_tab[i].data});
      end
`ifdef WB_FWD_EN
      chk($sformatf("alu%0d_fwd_valid", i), {63'd0, fwd_valid}, {63'd0, alu_tab[i].exp_wr});
`endif
      tick();
      chk($sformatf("alu%0d_pulse_end", i), {63'd0, gpr_bus_if.Rd_wr}, 64'd0);
    end

    // Load table: accept, one wait cycle, response
    for (int i = 0; i < 10; i++) begin
      drive_ld(ld_tab[i].addr, ld_tab[i].size, ld_tab[i].uns, ld_tab[i].off);
      tick();
      idle_inputs();
      chk($sformatf("ld%0d_rdy_wait", i), {63'd0, mem_rdy}, 64'd0);
      ld_rsp_valid = 1'b1;
      ld_rsp_data  = ld_tab[i].rsp;
      tick();
      idle_inputs();
      exp_instret = exp_instret + 64'd1;
      chk($sformatf("ld%0d_rd_wr", i), {63'd0, gpr_bus_if.Rd_wr}, {63'd0, ld_tab[i].exp_wr});
      chk($sformatf("ld%0d_rd_addr", i), {59'd0, gpr_bus_if.Rd_addr}, {59'd0, ld_tab[i].addr});
      if (ld_tab[i].exp_wr)
        chk($sformatf("ld%0d_rd_data", i), {32'd0, gpr_bus_if.Rd_data}, {32'd0, ld_tab[i].exp_data});
      chk($sformatf("ld%0d_instret", i), instret, exp_instret);
      chk($sformatf("ld%0d_rdy_back", i), {63'd0, mem_rdy}, 64'd1);
    end

    // Half load with three wait cycles; response offered in the accept cycle is ignored
    drive_ld(5'd6, 2'b01, 1'b0, 2'd2);
    ld_rsp_valid = 1'b1;
    ld_rsp_data  = 32'h1111_1111;
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("wait3_rdy%0d", c), {63'd0, mem_rdy}, 64'd0);
      chk($sformatf("wait3_nowr%0d", c), {63'd0, gpr_bus_if.Rd_wr}, 64'd0);
      if (c < 2) tick();
    end
    ld_rsp_valid = 1'b1;
    ld_rsp_data  = 32'h8001_1234;
    tick();
    idle_inputs();
    exp_instret = exp_instret + 64'd1;
    chk("wait3_rd_wr",   {63'd0, gpr_bus_if.Rd_wr}, 64'd1);
    chk("wait3_rd_data", {32'd0, gpr_bus_if.Rd_data}, 64'hFFFF_8001);
    chk("wait3_instret", instret, exp_instret);

    // Faulted load
    drive_ld(5'd14, 2'b10, 1'b0, 2'd0);
    tick();
    idle_inputs();
    ld_rsp_valid = 1'b1;
    ld_rsp_err   = 1'b1;
    ld_rsp_data  = 32'hAAAA_AAAA;
    tick();
    idle_inputs();
    chk("fault_pulse",   {63'd0, ld_fault}, 64'd1);
    chk("fault_rd_wr",   {63'd0, gpr_bus_if.Rd_wr}, 64'd0);
    chk("fault_rd_addr", {59'd0, gpr_bus_if.Rd_addr}, 64'd14);
    chk("fault_instret", instret, exp_instret);
    chk("fault_rdy",     {63'd0, mem_rdy}, 64'd1);
    tick();
    chk("fault_pulse_end", {63'd0, ld_fault}, 64'd0);

    // Reset mid-WAIT_LD, then a stray response in IDLE
    drive_ld(5'd15, 2'b10, 1'b0, 2'd0);
    tick();
    idle_inputs();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    exp_instret = '0;
    chk("rst_wait_rdy", {63'd0, mem_rdy}, 64'd1);
    ld_rsp_valid = 1'b1;
    ld_rsp_data  = 32'h7777_7777;
    tick();
    idle_inputs();
    chk("rst_wait_nowr",    {63'd0, gpr_bus_if.Rd_wr}, 64'd0);
    chk("rst_wait_instret", instret, 64'd0);

    // Reset in the same cycle as the response: reset wins
    drive_ld(5'd16, 2'b10, 1'b0, 2'd0);
    tick();
    idle_inputs();
    reset_in     = 1'b1;
    ld_rsp_valid = 1'b1;
    ld_rsp_data  = 32'h3333_3333;
    tick();
    idle_inputs();
    reset_in = 1'b0;
    chk("rst_rsp_nowr",    {63'd0, gpr_bus_if.Rd_wr}, 64'd0);
    chk("rst_rsp_instret", instret, 64'd0);
    chk("rst_rsp_rdy",     {63'd0, mem_rdy}, 64'd1);

    // Four back-to-back ALU ops
    for (int k = 0; k < 4; k++) begin
      drive_alu(5'(k + 1), 32'h100 + 32'(k), 1'b1);
      tick();
      exp_instret = exp_instret + 64'd1;
      chk($sformatf("b2b%0d_rd_wr", k), {63'd0, gpr_bus_if.Rd_wr}, 64'd1);
      chk($sformatf("b2b%0d_rd_addr", k), {59'd0, gpr_bus_if.Rd_addr}, 64'(k + 1));
      chk($sformatf("b2b%0d_rd_data", k), {32'd0, gpr_bus_if.Rd_data}, 64'h100 + 64'(k));
    end
    idle_inputs();
    chk("b2b_instret", instret, 64'd4);
    tick();
    chk("b2b_pulse_end", {63'd0, gpr_bus_if.Rd_wr}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
